spatial_mult_accumulator: RTL and testbench

Temporal accumulator directly downstream of the spatial shift-add multiplier tree. Each accepted beat is one signed partial dot-product from the shift-add output. The block sign-extends and sums a programmable number of beats into a wide accumulator, then presents the total on a valid/ready output. It sits between the multiplier array and the output buffer, so long dot products (more than VEC_SIZE terms) can be built across cycles.

---
 rtl/spatial_mult_accumulator.sv | 104 ++++++++++
 tb/tb_spatial_mult_accumulator.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/spatial_mult_accumulator.sv
// Temporal accumulator behind the shift-add multiplier tree.
// Sums a programmed number of signed beats into a wide register and presents the total.
module spatial_mult_accumulator #(
  parameter int PRECISION = 8,
  parameter int VEC_SIZE  = 1,
  parameter int IN_WIDTH  = (2*PRECISION)+2+$clog2(VEC_SIZE),
  parameter int ACC_WIDTH = 32,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [CNT_WIDTH-1:0] num_acc,
  input  logic                 in_valid,
  input  logic [IN_WIDTH-1:0]  in_data,
  output logic                 in_ready,
  output logic                 out_valid,
  output logic [ACC_WIDTH-1:0] out_data,
  output logic                 out_ovf,
  input  logic                 out_ready,
  output logic                 busy
);

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    DONE
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [ACC_WIDTH-1:0] acc;
  logic [CNT_WIDTH-1:0] count;
  logic [CNT_WIDTH-1:0] n_reg;
  logic                 ovf;

  logic [ACC_WIDTH-1:0] beat_ext;
  logic [ACC_WIDTH-1:0] sum;
  logic                 fire;
  logic                 last;
  logic                 add_ovf;

  assign beat_ext = ACC_WIDTH'($signed(in_data));
  assign sum      = acc + beat_ext;
  assign add_ovf  = (acc[ACC_WIDTH-1] == beat_ext[ACC_WIDTH-1]) &&
                    (sum[ACC_WIDTH-1] != acc[ACC_WIDTH-1]);
  assign fire     = in_valid && in_ready;
  assign last     = (count == n_reg - CNT_WIDTH'(1));

  assign busy     = (state != IDLE);
  assign out_data = acc;
  assign out_ovf  = ovf;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next state and handshake decode; in_ready/out_valid depend on state only.
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    unique case (state)
      IDLE: begin
        if (start)
          state_nxt = (num_acc == '0) ? DONE : ACCUM;
      end
      ACCUM: begin
        in_ready = 1'b1;
        if (in_valid && last)
          state_nxt = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready)
          state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Accumulator, beat counter and sticky overflow.
  always_ff @(posedge clk) begin
    if (reset) begin
      acc   <= '0;
      count <= '0;
      n_reg <= '0;
      ovf   <= 1'b0;
    end else if (state == IDLE && start) begin
      acc   <= '0;
      count <= '0;
      n_reg <= num_acc;
      ovf   <= 1'b0;
    end else if (fire) begin
      acc   <= sum;
      count <= count + CNT_WIDTH'(1);
      if (add_ovf) ovf <= 1'b1;
    end
  end

endmodule

// File: tb/tb_spatial_mult_accumulator.sv
// Bench for spatial_mult_accumulator.
// Scoreboard of expected totals, popped on each output handshake.
module tb_spatial_mult_accumulator;

  localparam int PRECISION = 8;
  localparam int VEC_SIZE  = 1;
  localparam int IN_WIDTH  = 18;
  localparam int ACC_WIDTH = 20;
  localparam int CNT_WIDTH = 16;
  localparam longint AMAX = (64'sd1 <<< (ACC_WIDTH-1)) - 1;
  localparam longint AMIN = -(64'sd1 <<< (ACC_WIDTH-1));
  localparam longint AMOD = 64'sd1 <<< ACC_WIDTH;

  logic clk = 1'b0;
  logic reset;
  logic start;
  logic [CNT_WIDTH-1:0] num_acc;
  logic in_valid;
  logic signed [IN_WIDTH-1:0] in_data;
  logic in_ready;
  logic out_valid;
  logic signed [ACC_WIDTH-1:0] out_data;
  logic out_ovf;
  logic out_ready;
  logic busy;

  spatial_mult_accumulator #(
    .PRECISION(PRECISION),
    .VEC_SIZE (VEC_SIZE),
    .ACC_WIDTH(ACC_WIDTH),
    .CNT_WIDTH(CNT_WIDTH)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .num_acc  (num_acc),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .out_valid(out_valid),
    .out_data (out_data),
    .out_ovf  (out_ovf),
    .out_ready(out_ready),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    longint data;
    bit     ovf;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int vectors = 0;
  int miscompares = 0;
  int results = 0;
  int accepted = 0;
  int sent = 0;

  task automatic check(input string tag,
                       input logic signed [63:0] obs,
                       input logic signed [63:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input int beats[$]);
    exp_t r;
    longint a;
    longint s;
    a = 0;
    r.ovf = 1'b0;
    foreach (beats[i]) begin
      s = a + longint'(beats[i]);
      if (s > AMAX) begin
        s = s - AMOD;
        r.ovf = 1'b1;
      end else if (s < AMIN) begin
        s = s + AMOD;
        r.ovf = 1'b1;
      end
      a = s;
    end
    r.data = a;
    return r;
  endfunction

  // Result monitor: compare on the output handshake.
  always @(negedge clk) begin
    if (!reset && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        check("sb_underflow", 1, 0);
      end else begin
        mon_e = sb.pop_front();
        check("out_data", out_data, mon_e.data);
        check("out_ovf", out_ovf, mon_e.ovf);
        results++;
      end
    end
  end

  // Count accepted input beats.
  always @(posedge clk) begin
    if (!reset && in_valid && in_ready) accepted++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input int n);
    start   = 1'b1;
    num_acc = CNT_WIDTH'(n);
    tick();
    start   = 1'b0;
    num_acc = 16'hBEEF;
  endtask

  task automatic send_beat(input int v);
    int k;
    in_valid = 1'b1;
    in_data  = IN_WIDTH'(v);
    k = 0;
    while (!in_ready && k < 100) begin
      tick();
      k++;
    end
    if (k == 100) check("beat_timeout", 0, 1);
    else sent++;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_done();
    int k;
    k = 0;
    while (!out_valid && k < 200) begin
      tick();
      k++;
    end
    if (k == 200) check("done_timeout", 0, 1);
  endtask

  task automatic run(input int beats[$], input int gap);
    sb.push_back(model(beats));
    do_start(beats.size());
    foreach (beats[i]) begin
      if (i > 0) repeat (gap) tick();
      send_beat(beats[i]);
    end
    check("lat_valid", out_valid, 1);
    check("done_inrdy", in_ready, 0);
  endtask

  task automatic finish_out();
    wait_done();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("idle_after_hs", busy, 0);
  endtask

  initial begin
    int q[$];
    exp_t z;
    int r0;
    reset     = 1'b1;
    start     = 1'b0;
    num_acc   = '0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    repeat (2) tick();
    check("rst_busy", busy, 0);
    check("rst_valid", out_valid, 0);
    check("rst_inrdy", in_ready, 0);
    check("rst_data", out_data, 0);
    check("rst_ovf", out_ovf, 0);
    reset = 1'b0;
    tick();

    // Basic sum
    q = {10, -3, 7, 100};
    run(q, 0);
    finish_out();

    // Stalls on both sides
    q = {5, 6, 7};
    run(q, 2);
    repeat (5) begin
      check("stall_hold", out_data, 18);
      check("stall_valid", out_valid, 1);
      tick();
    end
    finish_out();

    // Zero length
    z.data = 0;
    z.ovf  = 1'b0;
    sb.push_back(z);
    do_start(0);
    check("zero_done", out_valid, 1);
    finish_out();

    // Start pulsed during ACCUM is ignored
    z.data = 3;
    sb.push_back(z);
    do_start(2);
    start   = 1'b1;
    num_acc = '0;
    tick();
    start   = 1'b0;
    check("ign_busy", busy, 1);
    send_beat(1);
    send_beat(2);
    check("ign_valid", out_valid, 1);
    finish_out();

    // Sign extension and overflow
    q = {-131072, -131072, -131072, -131072, -131072};
    run(q, 0);
    check("ovf_data", out_data, 393216);
    finish_out();
    q = {1};
    run(q, 0);
    finish_out();

    // Reset mid-operation
    do_start(8);
    send_beat(4);
    send_beat(4);
    send_beat(4);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("mid_busy", busy, 0);
    check("mid_valid", out_valid, 0);
    check("mid_data", out_data, 0);
    check("mid_inrdy", in_ready, 0);
    q = {4, 4};
    run(q, 0);
    finish_out();

    // Back-to-back runs, beat presented early in IDLE
    out_ready = 1'b1;
    r0 = results;
    for (int k = 1; k <= 3; k++) begin
      in_valid = 1'b1;
      in_data  = IN_WIDTH'(k);
      q = {k};
      run(q, 0);
      tick();
      check("b2b_idle", busy, 0);
    end
    out_ready = 1'b0;
    tick();
    check("b2b_pulses", results - r0, 3);
    check("accepted", accepted, sent);
    check("sb_empty", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
